// File: rtl/ram_wb_arb2.sv
// Two-master Wishbone B3 round-robin arbiter in front of a single RAM slave.
// Whole bus cycles are granted (bursts never split); a watchdog errors a stalled strobe.
module ram_wb_arb2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] wdog_q;
  logic       wd_err_q;

  logic g0, g1, stb_g, term, wd_clr;

  assign g0     = (state_q == GNT0);
  assign g1     = (state_q == GNT1);
  assign stb_g  = (g0 & m0_stb_i) | (g1 & m1_stb_i);
  assign term   = s_ack_i | s_err_i | s_rty_i;
  assign wd_clr = (state_d != state_q) | ~stb_g | term | wd_err_q;

  // Grant decision only looks at registered state; cyc changes take effect next edge.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wdog_q   <= 8'd0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wd_err_q <= 1'b0;
      if (wd_clr) begin
        wdog_q <= 8'd0;
      end else if (wdog_q == TO_M1) begin
        wdog_q   <= 8'd0;
        wd_err_q <= 1'b1;
      end else begin
        wdog_q <= wdog_q + 8'd1;
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (g0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (g1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  // During the watchdog error cycle the slave is detached and its own terminations dropped.
  assign s_stb_o  = stb_g & ~wd_err_q;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i & ~wd_err_q;
  assign m0_err_o = g0 & (s_err_i | wd_err_q);
  assign m0_rty_o = g0 & s_rty_i & ~wd_err_q;
  assign m1_ack_o = g1 & s_ack_i & ~wd_err_q;
  assign m1_err_o = g1 & (s_err_i | wd_err_q);
  assign m1_rty_o = g1 & s_rty_i & ~wd_err_q;

endmodule
